// File: rtl/ifu_prefetch.sv
// Prefetching instruction fetch unit: issues sequential reads to a one-cycle
// instruction memory and buffers {PC+4, instruction} pairs for decode.
module ifu_prefetch #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [ADDR_W-1:0]          mux_branch_out,
  input  logic                       Branch_signal,
  input  logic [ADDR_W-1:0]          ReadData1,
  input  logic                       sel_JR,
  input  logic                       PCWrite,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [DATA_W-1:0]          imem_rdata,
  output logic [DATA_W-1:0]          Instruction,
  output logic [ADDR_W-1:0]          PCAddResult,
  output logic                       inst_valid,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH-1);

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_req_pc;
  logic              r_inflight;
  logic              r_drop;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [OCC_W-1:0]  r_count;
  logic [DATA_W-1:0] r_inst_q [DEPTH];
  logic [ADDR_W-1:0] r_pc4_q  [DEPTH];

  logic              w_redirect;
  logic [ADDR_W-1:0] w_target_raw;
  logic [ADDR_W-1:0] w_target;
  logic              w_valid;
  logic              w_deq;
  logic              w_enq;
  logic [OCC_W:0]    w_pending;
  logic              w_req;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_redirect   = sel_JR | Branch_signal;
  assign w_target_raw = sel_JR ? ReadData1 : mux_branch_out;
  assign w_target     = {w_target_raw[ADDR_W-1:2], 2'b00};

  assign w_valid = (r_count != '0);
  assign w_deq   = w_valid & PCWrite;

  // Entries already stored plus the one still in flight, minus the one
  // leaving now; issuing only while this is below DEPTH rules out overflow.
  assign w_pending = {1'b0, r_count} + (OCC_W+1)'(r_inflight) - (OCC_W+1)'(w_deq);
  assign w_req     = Reset & ~w_redirect & (w_pending < (OCC_W+1)'(DEPTH));

  assign w_enq = r_inflight & ~r_drop & Reset & ~w_redirect;

  assign imem_req    = w_req;
  assign imem_addr   = r_fetch_pc;
  assign inst_valid  = w_valid;
  assign occupancy   = r_count;
  assign Instruction = w_valid ? r_inst_q[r_rd_ptr] : '0;
  assign PCAddResult = w_valid ? r_pc4_q[r_rd_ptr]  : '0;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_inflight <= 1'b0;
      r_drop     <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else if (w_redirect) begin
      r_fetch_pc <= w_target;
      r_inflight <= 1'b0;
      r_drop     <= r_inflight;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_drop     <= 1'b0;
      r_inflight <= w_req;
      if (w_req) begin
        r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
        r_req_pc   <= r_fetch_pc;
      end
      if (w_enq) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_deq) r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + OCC_W'(1);
        2'b01:   r_count <= r_count - OCC_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero while the FIFO is empty.
  always_ff @(posedge Clk) begin
    if (w_enq) begin
      r_inst_q[r_wr_ptr] <= imem_rdata;
      r_pc4_q[r_wr_ptr]  <= r_req_pc + ADDR_W'(4);
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: scoreboard of expected fetch PCs popped on every
// dequeue, table of redirect vectors, plus reset/stall/wrap sequences.
module tb_ifu_prefetch;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] mux_branch_out;
  logic        Branch_signal;
  logic [31:0] ReadData1;
  logic        sel_JR;
  logic        PCWrite;

  logic        imem_req,    b_imem_req;
  logic [31:0] imem_addr,   b_imem_addr;
  logic [31:0] imem_rdata,  b_imem_rdata;
  logic [31:0] Instruction, b_Instruction;
  logic [31:0] PCAddResult, b_PCAddResult;
  logic        inst_valid,  b_inst_valid;
  logic [2:0]  occupancy,   b_occupancy;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic        br;
    logic [31:0] br_tgt;
    logic        jr;
    logic [31:0] jr_tgt;
    logic [31:0] exp_pc;
  } redir_vec_t;
  redir_vec_t vecs[4];

  always #5 Clk = ~Clk;

  ifu_prefetch #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0)) u_dut (
    .Clk(Clk), .Reset(Reset), .mux_branch_out(mux_branch_out),
    .Branch_signal(Branch_signal), .ReadData1(ReadData1), .sel_JR(sel_JR),
    .PCWrite(PCWrite), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .Instruction(Instruction),
    .PCAddResult(PCAddResult), .inst_valid(inst_valid), .occupancy(occupancy)
  );

  ifu_prefetch #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
    .Clk(Clk), .Reset(Reset), .mux_branch_out(mux_branch_out),
    .Branch_signal(Branch_signal), .ReadData1(ReadData1), .sel_JR(sel_JR),
    .PCWrite(PCWrite), .imem_req(b_imem_req), .imem_addr(b_imem_addr),
    .imem_rdata(b_imem_rdata), .Instruction(b_Instruction),
    .PCAddResult(b_PCAddResult), .inst_valid(b_inst_valid), .occupancy(b_occupancy)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a | 32'hA000_0000;
  endfunction

  // One-cycle memories: request sampled mid-cycle, data driven just after the edge.
  logic        req_s, b_req_s;
  logic [31:0] addr_s, b_addr_s;
  initial begin
    imem_rdata = 32'hDEAD_BEEF; b_imem_rdata = 32'hDEAD_BEEF;
    req_s = 1'b0; b_req_s = 1'b0; addr_s = '0; b_addr_s = '0;
  end
  always @(negedge Clk) begin
    req_s = imem_req;   addr_s = imem_addr;
    b_req_s = b_imem_req; b_addr_s = b_imem_addr;
  end
  always @(posedge Clk) begin
    #1;
    imem_rdata   = req_s   ? mem_word(addr_s)   : 32'hDEAD_BEEF;
    b_imem_rdata = b_req_s ? mem_word(b_addr_s) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted head is compared against the next expected PC.
  always @(negedge Clk) begin
    if (occupancy > 3'd4) chk("occupancy_bound", {29'd0, occupancy}, 32'd4);
    if (Reset && inst_valid && PCWrite && !Branch_signal && !sel_JR) begin
      if (sb.size() == 0) begin
        chk("unexpected_deq_pc4", PCAddResult, 32'hFFFF_FFFF);
      end else begin
        logic [31:0] pc;
        pc = sb.pop_front();
        chk("deq_inst", Instruction, mem_word(pc));
        chk("deq_pc4", PCAddResult, pc + 32'd4);
        $display("deq pc=%h inst=%h pc4=%h", pc, Instruction, PCAddResult);
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset(input logic pw);
    Reset = 1'b0;
    PCWrite = pw;
    Branch_signal = 1'b0;
    sel_JR = 1'b0;
    sb.delete();
    #1;
    chk("req_in_reset", {31'd0, imem_req}, 32'd0);
    tick();
    tick();
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_occ", {29'd0, occupancy}, 32'd0);
    chk("rst_inst", Instruction, 32'd0);
    chk("rst_pc4", PCAddResult, 32'd0);
    Reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{br: 1'b1, br_tgt: 32'h0000_0102, jr: 1'b0, jr_tgt: 32'h0,         exp_pc: 32'h0000_0100};
    vecs[1] = '{br: 1'b1, br_tgt: 32'h0000_0300, jr: 1'b1, jr_tgt: 32'h0000_0200, exp_pc: 32'h0000_0200};
    vecs[2] = '{br: 1'b0, br_tgt: 32'h0000_0400, jr: 1'b1, jr_tgt: 32'h0000_01F3, exp_pc: 32'h0000_01F0};
    vecs[3] = '{br: 1'b1, br_tgt: 32'hFFFF_FFFE, jr: 1'b0, jr_tgt: 32'h0,         exp_pc: 32'hFFFF_FFFC};

    Reset = 1'b0; PCWrite = 1'b0; Branch_signal = 1'b0; sel_JR = 1'b0;
    mux_branch_out = '0; ReadData1 = '0;
    @(posedge Clk); #1;

    // Streaming from reset, plus address wrap on the second instance
    do_reset(1'b1);
    for (int k = 0; k < 8; k++) sb.push_back(32'(k * 4));
    @(negedge Clk);
    chk("c0_req", {31'd0, imem_req}, 32'd1);
    chk("c0_addr", imem_addr, 32'h0);
    chk("wrap_c0_addr", b_imem_addr, 32'hFFFF_FFF8);
    tick();
    chk("c1_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    chk("c2_inst", Instruction, 32'hA000_0000);
    chk("c2_pc4", PCAddResult, 32'h4);
    for (int k = 0; k < 8; k++) begin
      chk("stream_valid", {31'd0, inst_valid}, 32'd1);
      if (k == 0) begin chk("wrap_inst0", b_Instruction, 32'hFFFF_FFF8); chk("wrap_pc4_0", b_PCAddResult, 32'hFFFF_FFFC); end
      if (k == 1) begin chk("wrap_inst1", b_Instruction, 32'hFFFF_FFFC); chk("wrap_pc4_1", b_PCAddResult, 32'h0); end
      if (k == 2) begin chk("wrap_inst2", b_Instruction, 32'hA000_0000); chk("wrap_pc4_2", b_PCAddResult, 32'h4); end
      tick();
    end
    PCWrite = 1'b0;
    chk("stream_sb_empty", 32'(sb.size()), 32'd0);

    // Stall until full, then drain with no gap
    do_reset(1'b0);
    repeat (6) tick();
    @(negedge Clk);
    chk("stall_occ", {29'd0, occupancy}, 32'd4);
    chk("stall_req", {31'd0, imem_req}, 32'd0);
    chk("stall_inst", Instruction, 32'hA000_0000);
    chk("stall_pc4", PCAddResult, 32'h4);
    tick(); tick();
    @(negedge Clk);
    chk("stall_hold_inst", Instruction, 32'hA000_0000);
    chk("stall_hold_pc4", PCAddResult, 32'h4);
    chk("stall_hold_occ", {29'd0, occupancy}, 32'd4);
    tick();
    for (int k = 0; k < 5; k++) sb.push_back(32'(k * 4));
    PCWrite = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("drain_valid", {31'd0, inst_valid}, 32'd1);
      tick();
    end
    PCWrite = 1'b0;
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);

    // Redirects with 3 entries buffered and one fetch in flight
    for (int v = 0; v < 4; v++) begin
      do_reset(1'b0);
      repeat (4) tick();
      chk("pre_redir_occ", {29'd0, occupancy}, 32'd3);
      Branch_signal = vecs[v].br; mux_branch_out = vecs[v].br_tgt;
      sel_JR = vecs[v].jr; ReadData1 = vecs[v].jr_tgt;
      @(negedge Clk);
      chk("redir_cycle_req", {31'd0, imem_req}, 32'd0);
      tick();
      Branch_signal = 1'b0; sel_JR = 1'b0; PCWrite = 1'b1;
      for (int k = 0; k < 4; k++) sb.push_back(vecs[v].exp_pc + 32'(k * 4));
      chk("redir_occ", {29'd0, occupancy}, 32'd0);
      chk("redir_valid", {31'd0, inst_valid}, 32'd0);
      @(negedge Clk);
      chk("redir_addr", imem_addr, vecs[v].exp_pc);
      chk("redir_req", {31'd0, imem_req}, 32'd1);
      tick();
      chk("redir_r1_valid", {31'd0, inst_valid}, 32'd0);
      tick();
      chk("redir_first_inst", Instruction, mem_word(vecs[v].exp_pc));
      chk("redir_first_pc4", PCAddResult, vecs[v].exp_pc + 32'd4);
      for (int k = 0; k < 4; k++) begin
        chk("redir_stream_valid", {31'd0, inst_valid}, 32'd1);
        tick();
      end
      PCWrite = 1'b0;
      chk("redir_sb_empty", 32'(sb.size()), 32'd0);
    end

    // Reset mid-stream: two entries buffered and one fetch in flight
    do_reset(1'b0);
    repeat (3) tick();
    chk("pre_rst_occ", {29'd0, occupancy}, 32'd2);
    Reset = 1'b0;
    @(negedge Clk);
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    tick();
    chk("midrst_valid", {31'd0, inst_valid}, 32'd0);
    chk("midrst_occ", {29'd0, occupancy}, 32'd0);
    Reset = 1'b1; PCWrite = 1'b1;
    for (int k = 0; k < 4; k++) sb.push_back(32'(k * 4));
    @(negedge Clk);
    chk("midrst_addr", imem_addr, 32'h0);
    tick(); tick();
    chk("midrst_first_inst", Instruction, 32'hA000_0000);
    for (int k = 0; k < 4; k++) begin
      chk("midrst_stream_valid", {31'd0, inst_valid}, 32'd1);
      tick();
    end
    PCWrite = 1'b0;
    chk("midrst_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
- Parametrised successor to the single-instruction fetch unit. Holds a fetch PC and issues requests to a one-cycle-latency instruction memory.
- Fetched instructions are buffered in a DEPTH-entry FIFO together with their PC+4. Decode drains the FIFO through a valid/ready handshake, with PCWrite as ready.
- Branch and JR redirects flush the FIFO and discard the in-flight fetch.
- Sits between the PC/branch-mux logic and the IF/ID pipeline register.

Parameters:
ADDR_W, 32, PC/address width
DATA_W, 32, instruction width
DEPTH, 4, FIFO entries; legal values are 2 to 16
RESET_PC, 0, fetch PC after reset; low 2 bits must be 0

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  synchronous reset, active-low (0 = reset)
mux_branch_out  in  ADDR_W  branch target
Branch_signal  in  1  branch taken; redirect to mux_branch_out
ReadData1  in  ADDR_W  JR target (register value)
sel_JR  in  1  JR taken; redirect to ReadData1
PCWrite  in  1  decode ready; dequeue head when inst_valid=1
imem_req  out  1  memory read request this cycle
imem_addr  out  ADDR_W  request address (= fetch_pc)
imem_rdata  in  DATA_W  read data; valid exactly one cycle after an accepted imem_req
Instruction  out  DATA_W  FIFO head instruction
PCAddResult  out  ADDR_W  FIFO head PC+4
inst_valid  out  1  FIFO non-empty
occupancy  out  clog2(DEPTH+1)  FIFO entry count

Behaviour:
- Reset (edge with Reset=0):
  - fetch_pc=RESET_PC; FIFO emptied; inflight=0; drop=0.
  - Outputs: inst_valid=0, occupancy=0, Instruction=0, PCAddResult=0.
  - imem_req=0 while Reset=0.
  - A response arriving in the cycle after a reset edge is ignored.
- deq = inst_valid & PCWrite.
- redirect = sel_JR | Branch_signal.
  - Target priority: sel_JR wins, then ReadData1, else mux_branch_out.
  - Target bits [1:0] are forced to 0.
- Issue rule (combinational):
  - imem_req = Reset & ~redirect & ((occupancy + inflight - deq) < DEPTH).
  - imem_addr = fetch_pc.
- On an edge with imem_req=1: fetch_pc <= fetch_pc+4, wrapping modulo 2^ADDR_W; inflight <= 1. Otherwise inflight <= 0.
- Response: in the cycle after an issue, if inflight=1 and drop=0, {fetch address+4, imem_rdata} is written to the FIFO tail at the edge. The issuing address is held internally for this.
- Enqueue and dequeue on the same edge: occupancy is unchanged.
- The issue rule guarantees no overflow. An enqueue into a full FIFO is a design error; the bench asserts it never happens.
- Dequeue with empty FIFO: impossible, because deq is gated by inst_valid.
- Redirect edge:
  - fetch_pc <= target; FIFO emptied (pointers and count cleared).
  - drop <= inflight, so the response of the pre-redirect request is discarded next cycle.
  - Any same-edge enqueue or dequeue is suppressed.
  - No request is issued in the redirect cycle.
- drop clears on the next edge.
- Latency:
  - Request at cycle N gives data written at edge N+1 and inst_valid=1 in cycle N+2.
  - Redirect sampled at edge R gives a request to the target in cycle R (after the edge) and inst_valid in cycle R+2.
- Throughput: with PCWrite held 1, one instruction per cycle in steady state for any DEPTH≥2.
- Stall (PCWrite=0): the FIFO fills to DEPTH and then imem_req=0. Instruction and PCAddResult hold stable while the head is not dequeued.
- Reset overrides redirect. Reset mid-stream discards everything, including the in-flight response.

Test Plan:
- Reset then Reset=1, memory[addr]=addr|0xA000_0000, PCWrite=1.
  - Cycle 0: req at 0x0.
  - Cycle 2: inst_valid=1, Instruction=0xA0000000, PCAddResult=0x4.
  - Then one instruction per cycle: 0x4, 0x8, ...
- PCWrite=0 from cycle 0, DEPTH=4.
  - occupancy reaches 4; imem_req=0 thereafter; head holds 0x0/0x4.
  - Raise PCWrite: entries 0x0, 0x4, 0x8, 0xC emerge in order with no gap, then 0x10 follows.
- Branch_signal=1, mux_branch_out=0x0000_0102 while the FIFO holds 3 entries and a request is in flight.
  - Next cycle: occupancy=0, imem_addr=0x100.
  - The stale response is not enqueued.
  - First valid Instruction is from 0x100, with PCAddResult=0x104.
- sel_JR=1 (ReadData1=0x200) and Branch_signal=1 (mux_branch_out=0x300) on the same edge → fetch resumes at 0x200.
- RESET_PC=0xFFFF_FFF8, PCWrite=1 → fetch order 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000. PCAddResult for 0xFFFFFFFC is 0x0.
- Reset=0 asserted mid-stream with occupancy=2 and a request in flight.
  - Next cycle: inst_valid=0, occupancy=0.
  - After release, first Instruction is from RESET_PC; no stale entry appears.
